// File: rtl/dm.sv
// Data memory for the memory stage: byte-addressed, little-endian word array
// with sub-word stores, sign/zero-extended loads, fault detection, a sticky
// error flag and a committed-store counter. Reset clears the whole array.
module dm #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  width,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        err_sticky,
  output logic [31:0] store_cnt
);

  localparam int          WORDS = 1 << DEPTH_LOG2;
  // One past the last valid byte address; 33 bits so DEPTH_LOG2=30 still fits.
  localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  logic [31:0]           mem_q [WORDS];
  logic                  err_q;
  logic [31:0]           store_cnt_q;
  logic [31:0]           store_cnt_d;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           cur_word;
  logic [31:0]           wr_word_d;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  commit;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sx);
    return sx ? {{16{h[15]}}, h} : {16'd0, h};
  endfunction

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sx);
    return sx ? {{24{b[7]}}, b} : {24'd0, b};
  endfunction

  assign idx          = addr[DEPTH_LOG2+1:2];
  assign cur_word     = mem_q[idx];
  assign out_of_range = ({1'b0, addr} >= LIMIT);
  assign half_sel     = addr[1] ? cur_word[31:16] : cur_word[15:0];
  assign byte_sel     = cur_word[8*addr[1:0] +: 8];
  assign commit       = we & ~fault;
  assign store_cnt_d  = store_cnt_q + 32'd1;

  // Alignment rules per access width; illegal width counts as a fault.
  always_comb begin
    misaligned = 1'b0;
    case (width)
      W_WORD:  misaligned = (addr[1:0] != 2'b00);
      W_HALF:  misaligned = addr[0];
      W_BYTE:  misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  assign fault = (we | re) & (out_of_range | misaligned);

  // Merge store data into the addressed word, leaving untouched lanes intact.
  always_comb begin
    wr_word_d = cur_word;
    case (width)
      W_WORD: wr_word_d = wdata;
      W_HALF: begin
        if (addr[1]) wr_word_d[31:16] = wdata[15:0];
        else         wr_word_d[15:0]  = wdata[15:0];
      end
      W_BYTE:  wr_word_d[8*addr[1:0] +: 8] = wdata[7:0];
      default: wr_word_d = cur_word;
    endcase
  end

  // Load path reads pre-edge contents, so same-cycle read/write returns old data.
  always_comb begin
    rdata = 32'd0;
    if (rst_n && re && !fault) begin
      case (width)
        W_WORD:  rdata = cur_word;
        W_HALF:  rdata = ext_half(half_sel, sign_ext);
        W_BYTE:  rdata = ext_byte(byte_sel, sign_ext);
        default: rdata = 32'd0;
      endcase
    end
  end

  // Storage array: cleared asynchronously, written on committed stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= 32'd0;
    end else if (commit) begin
      mem_q[idx] <= wr_word_d;
    end
  end

  // Sticky error flag and wrapping store counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      store_cnt_q <= 32'd0;
    end else begin
      if (fault)  err_q       <= 1'b1;
      if (commit) store_cnt_q <= store_cnt_d;
    end
  end

  assign err_sticky = err_q;
  assign store_cnt  = store_cnt_q;

`ifndef SYNTHESIS
  // Store trace: one line per committed store with the full resulting word.
  always @(posedge clk) begin
    if (rst_n && commit)
      $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, wr_word_d);
  end
`endif

endmodule

// File: tb/tb_dm.sv
// Self-checking bench for dm: directed scenarios plus randomized traffic,
// compared against a byte-addressed reference memory model.
module tb_dm;

  localparam int BYTES = 4 << 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [1:0]  width = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] rdata;
  logic        fault;
  logic        err_sticky;
  logic [31:0] store_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  ref_mem [BYTES];
  logic [31:0] ref_cnt;
  logic        ref_err;

  logic [31:0] obs_rdata, exp_rdata;
  logic        obs_fault, exp_fault;

  dm dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .width(width), .sign_ext(sign_ext),
    .rdata(rdata), .fault(fault), .err_sticky(err_sticky), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic m_fault(input logic [31:0] a, input logic [1:0] w, input logic act);
    if (!act) return 1'b0;
    if (a >= BYTES || w == 2'd3) return 1'b1;
    return (a % nbytes(w)) != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] w, input logic sx);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nbytes(w); i++) v[8*i +: 8] = ref_mem[a + i];
    if (w == 2'd1 && sx) v = 32'($signed(v[15:0]));
    if (w == 2'd2 && sx) v = 32'($signed(v[7:0]));
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'd0;
    ref_cnt = 32'd0;
    ref_err = 1'b0;
  endtask

  // Drive one request for a full cycle; records observed/expected load and
  // fault before the edge, then advances the model across the edge.
  task automatic txn(input logic w, input logic r, input logic [1:0] wd, input logic sx,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; re = r; width = wd; sign_ext = sx; addr = a; wdata = d; pc = pc + 32'd4;
    #1;
    obs_rdata = rdata;
    obs_fault = fault;
    exp_fault = m_fault(a, wd, w | r);
    exp_rdata = (r && !exp_fault) ? m_read(a, wd, sx) : 32'd0;
    @(posedge clk);
    if (rst_n && exp_fault) ref_err = 1'b1;
    if (rst_n && w && !exp_fault) begin
      for (int i = 0; i < nbytes(wd); i++) ref_mem[a + i] = d[8*i +: 8];
      ref_cnt = ref_cnt + 32'd1;
    end
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic test_reset();
    m_clear();
    rst_n = 1'b0;
    re = 1'b1; width = 2'd0; addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (store_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", store_cnt); end
    n_chk++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_sticky); end
    n_chk++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    @(negedge clk);
    re = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_word_subword();
    txn(1, 0, 2'd0, 0, 32'h10, 32'h12345678);
    n_chk++; if (store_cnt !== 32'd1) begin n_fail++; $display("FAIL sw_cnt: got %h want 1", store_cnt); end
    txn(0, 1, 2'd0, 0, 32'h10, 32'h0);
    n_chk++; if (obs_rdata !== 32'h12345678) begin n_fail++; $display("FAIL lw: got %h want 12345678", obs_rdata); end
    txn(1, 0, 2'd2, 0, 32'h13, 32'h000000AB);
    txn(0, 1, 2'd0, 0, 32'h10, 32'h0);
    n_chk++; if (obs_rdata !== 32'hAB345678) begin n_fail++; $display("FAIL sb_word: got %h want AB345678", obs_rdata); end
    txn(0, 1, 2'd2, 1, 32'h13, 32'h0);
    n_chk++; if (obs_rdata !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL lb: got %h want FFFFFFAB", obs_rdata); end
    txn(0, 1, 2'd2, 0, 32'h13, 32'h0);
    n_chk++; if (obs_rdata !== 32'h000000AB) begin n_fail++; $display("FAIL lbu: got %h want 000000AB", obs_rdata); end
    txn(0, 1, 2'd1, 1, 32'h12, 32'h0);
    n_chk++; if (obs_rdata !== 32'hFFFFAB34) begin n_fail++; $display("FAIL lh: got %h want FFFFAB34", obs_rdata); end
    txn(1, 0, 2'd1, 0, 32'h10, 32'h0000BEEF);
    txn(0, 1, 2'd1, 0, 32'h10, 32'h0);
    n_chk++; if (obs_rdata !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu_low: got %h want 0000BEEF", obs_rdata); end
    n_chk++; if (store_cnt !== 32'd3) begin n_fail++; $display("FAIL sub_cnt: got %h want 3", store_cnt); end
    n_chk++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL no_err: got %b want 0", err_sticky); end
  endtask

  task automatic test_faults();
    logic [31:0] a_tab [4];
    logic [1:0]  w_tab [4];
    logic        st_tab [4];
    a_tab = '{32'h2, 32'h1, 32'h1000, 32'h20};
    w_tab = '{2'd0, 2'd1, 2'd0, 2'd3};
    st_tab = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      txn(st_tab[i], !st_tab[i], w_tab[i], 1'b1, a_tab[i], 32'hDEADBEEF);
      n_chk++; if (obs_fault !== 1'b1) begin n_fail++; $display("FAIL fault_%0d: got %b want 1", i, obs_fault); end
      n_chk++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL fault_rdata_%0d: got %h want 0", i, obs_rdata); end
      n_chk++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL fault_err_%0d: got %b want 1", i, err_sticky); end
      n_chk++; if (store_cnt !== 32'd3) begin n_fail++; $display("FAIL fault_cnt_%0d: got %h want 3", i, store_cnt); end
    end
    txn(0, 1, 2'd0, 0, 32'h0, 32'h0);
    n_chk++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL fault_mem0: got %h want 0", obs_rdata); end
    txn(0, 1, 2'd0, 0, 32'h20, 32'h0);
    n_chk++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL fault_mem20: got %h want 0", obs_rdata); end
    txn(0, 1, 2'd0, 0, 32'h0, 32'h0);
    n_chk++; if (obs_fault !== 1'b0) begin n_fail++; $display("FAIL aligned_nofault: got %b want 0", obs_fault); end
  endtask

  task automatic test_same_cycle();
    txn(1, 0, 2'd0, 0, 32'h10, 32'h11111111);
    txn(1, 1, 2'd0, 0, 32'h10, 32'h22222222);
    n_chk++; if (obs_rdata !== 32'h11111111) begin n_fail++; $display("FAIL rw_old: got %h want 11111111", obs_rdata); end
    txn(0, 1, 2'd0, 0, 32'h10, 32'h0);
    n_chk++; if (obs_rdata !== 32'h22222222) begin n_fail++; $display("FAIL rw_new: got %h want 22222222", obs_rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  w;
    logic        st, ld, sx;
    for (int n = 0; n < 300; n++) begin
      w  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) w = 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = 32'(BYTES - 1 - $urandom_range(0, 7));
      d  = $urandom;
      st = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      txn(st, ld, w, sx, a, d);
      n_chk++; if (obs_fault !== exp_fault) begin n_fail++; $display("FAIL rnd_fault[%0d] a=%h w=%0d: got %b want %b", n, a, w, obs_fault, exp_fault); end
      n_chk++; if (obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d] a=%h w=%0d: got %h want %h", n, a, w, obs_rdata, exp_rdata); end
      n_chk++; if (store_cnt !== ref_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %h want %h", n, store_cnt, ref_cnt); end
      n_chk++; if (err_sticky !== ref_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", n, err_sticky, ref_err); end
    end
    for (int i = 0; i < 64; i += 4) begin
      txn(0, 1, 2'd0, 0, 32'(i), 32'h0);
      n_chk++; if (obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL sweep[%0d]: got %h want %h", i, obs_rdata, exp_rdata); end
    end
  endtask

  task automatic test_mid_reset();
    txn(1, 0, 2'd0, 0, 32'h30, 32'hCAFEF00D);
    @(negedge clk);
    we = 1'b1; re = 1'b1; width = 2'd0; addr = 32'h30; wdata = 32'h55AA55AA;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (store_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_cnt: got %h want 0", store_cnt); end
    n_chk++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b want 0", err_sticky); end
    n_chk++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL mid_rdata: got %h want 0", rdata); end
    @(posedge clk);
    #1;
    n_chk++; if (store_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_edge_cnt: got %h want 0", store_cnt); end
    @(negedge clk);
    we = 1'b0; re = 1'b0; rst_n = 1'b1;
    m_clear();
    txn(0, 1, 2'd0, 0, 32'h30, 32'h0);
    n_chk++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_mem: got %h want 0", obs_rdata); end
    txn(0, 1, 2'd0, 0, 32'h10, 32'h0);
    n_chk++; if (obs_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_mem10: got %h want 0", obs_rdata); end
    txn(1, 0, 2'd0, 0, 32'h30, 32'h0BADCAFE);
    txn(0, 1, 2'd0, 0, 32'h30, 32'h0);
    n_chk++; if (obs_rdata !== 32'h0BADCAFE) begin n_fail++; $display("FAIL post_reset_rw: got %h want 0BADCAFE", obs_rdata); end
    n_chk++; if (store_cnt !== 32'd1) begin n_fail++; $display("FAIL post_reset_cnt: got %h want 1", store_cnt); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.store_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.store_cnt_q;
    #1;
    n_chk++; if (store_cnt !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wrap_pre: got %h want FFFFFFFF", store_cnt); end
    txn(1, 0, 2'd2, 0, 32'h40, 32'h7E);
    n_chk++; if (store_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap: got %h want 0", store_cnt); end
    txn(1, 0, 2'd0, 0, 32'h41, 32'h0);
    n_chk++; if (store_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_fault_nocount: got %h want 0", store_cnt); end
  endtask

  initial begin
    test_reset();
    test_word_subword();
    test_faults();
    test_same_cycle();
    test_random();
    test_mid_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
